// File: rtl/store_merge_unit.sv
// ---------------------------------------------------------------------------
// store_merge_unit
//
// Narrows a 32-bit register value to a byte, halfword or word and merges it
// into the addressed memory word. Byte and halfword stores use a
// read-modify-write: the containing word is read, the addressed lanes are
// replaced, and the merged word is written back. Word stores skip the read.
// Misaligned or reserved requests produce a one-cycle err pulse and perform
// no memory access.
//
// Parameters
//   LITTLE_END   1: addr[1:0]=0 maps to bits 7:0; 0: addr[1:0]=0 maps to 31:24
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   start_i      store request, only looked at while idle
//   op_i         store size: 00=SB, 01=SH, 10=SW, 11=reserved
//   addr_i       byte address of the store
//   wdata_i      register source (SB uses [7:0], SH uses [15:0])
//   busy_o       high whenever the unit is not idle
//   done_o       one-cycle completion pulse
//   err_o        one-cycle pulse for a misaligned or reserved request
//   mem_req_o    memory request, held until mem_ack_i
//   mem_we_o     1=write, 0=read, valid with mem_req_o
//   mem_addr_o   word-aligned memory address
//   mem_wdata_o  merged word to write
//   mem_rdata_i  read data, valid with mem_ack_i
//   mem_ack_i    completes the current access when seen with mem_req_o
// ---------------------------------------------------------------------------
module store_merge_unit #(
   parameter int LITTLE_END = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [1:0] OP_SB  = 2'b00;
   localparam logic [1:0] OP_SH  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   state_t      state_q, state_d;

   // Operands latched at acceptance; only the lane offset of the address is
   // needed after that, the word address lives in mem_addr_q.
   logic [1:0]  op_q, op_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] wdata_q, wdata_d;

   // Merge register: holds the word to be written (read word with the
   // store lanes replaced, or the raw register value for SW).
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;

   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;

   // A request is rejected when it is reserved or not naturally aligned.
   function automatic logic req_bad(input logic [1:0] op, input logic [1:0] a);
      logic bad;
      case (op)
         OP_SB:   bad = 1'b0;
         OP_SH:   bad = a[0];
         OP_SW:   bad = (a != 2'b00);
         OP_RSV:  bad = 1'b1;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Replace the addressed lanes of rdata with the narrowed store value.
   // Big-endian lane order mirrors the shift: lane n sits at byte (3-n).
   function automatic logic [31:0] merge_word(input logic [1:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] wd,
                                              input logic [31:0] rd);
      logic [4:0]  sh;
      logic [31:0] mask;
      logic [31:0] data;
      case (op)
         OP_SB: begin
            sh   = (LITTLE_END != 0) ? {a, 3'b000} : {~a, 3'b000};
            mask = 32'h0000_00FF << sh;
            data = {24'h00_0000, wd[7:0]} << sh;
         end
         OP_SH: begin
            sh   = (LITTLE_END != 0) ? {a[1], 4'b0000} : {~a[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            data = {16'h0000, wd[15:0]} << sh;
         end
         default: begin
            sh   = 5'd0;
            mask = 32'hFFFF_FFFF;
            data = wd;
         end
      endcase
      return (rd & ~mask) | (data & mask);
   endfunction

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (req_bad(op_i, addr_i[1:0])) begin
                  state_d = S_ERR;
               end else if (op_i == OP_SW) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (mem_ack_i) begin
               state_d = S_WR;
            end else begin
               state_d = S_RD;
            end
         end
         S_WR: begin
            if (mem_ack_i) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latching and merge datapath; everything holds unless the
   // unit is accepting a request or completing the read.
   always_comb begin
      op_d        = op_q;
      addr_lo_d   = addr_lo_q;
      wdata_d     = wdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d       = op_i;
               addr_lo_d  = addr_i[1:0];
               wdata_d    = wdata_i;
               mem_addr_d = {addr_i[31:2], 2'b00};
               if (op_i == OP_SW) begin
                  mem_wdata_d = wdata_i;
               end else begin
                  mem_wdata_d = mem_wdata_q;
               end
            end else begin
               op_d = op_q;
            end
         end
         S_RD: begin
            if (mem_ack_i) begin
               mem_wdata_d = merge_word(op_q, addr_lo_q, wdata_q, mem_rdata_i);
            end else begin
               mem_wdata_d = mem_wdata_q;
            end
         end
         default: begin
            op_d = op_q;
         end
      endcase
   end

   // Output decode from the next state so that every output is registered
   // and lines up with the state it belongs to.
   always_comb begin
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      case (state_d)
         S_IDLE: begin
            busy_d = 1'b0;
         end
         S_RD: begin
            busy_d    = 1'b1;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
         end
         S_WR: begin
            busy_d    = 1'b1;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
         end
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         S_ERR: begin
            busy_d = 1'b1;
            err_d  = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, operand and output registers; reset aborts any access.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         op_q        <= 2'b00;
         addr_lo_q   <= 2'b00;
         wdata_q     <= 32'h0000_0000;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_lo_q   <= addr_lo_d;
         wdata_q     <= wdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// ---------------------------------------------------------------------------
// Bench for store_merge_unit. Two instances (little- and big-endian lane
// order) see identical stimulus. Per-cycle stimulus and expected outputs
// are laid out in tables built from the latency rules and a byte-array
// merge model; one compare process checks both instances every cycle.
// ---------------------------------------------------------------------------
module tb_store_merge_unit;

   localparam int NC = 100;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        busy1, done1, err1, req1, we1;
   logic [31:0] maddr1, mwd1;
   logic        busy0, done0, err0, req0, we0;
   logic [31:0] maddr0, mwd0;

   store_merge_unit #(.LITTLE_END(1)) u_le1 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
      .addr_i(addr), .wdata_i(wdata), .busy_o(busy1), .done_o(done1),
      .err_o(err1), .mem_req_o(req1), .mem_we_o(we1), .mem_addr_o(maddr1),
      .mem_wdata_o(mwd1), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
   );

   store_merge_unit #(.LITTLE_END(0)) u_le0 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
      .addr_i(addr), .wdata_i(wdata), .busy_o(busy0), .done_o(done0),
      .err_o(err0), .mem_req_o(req0), .mem_we_o(we0), .mem_addr_o(maddr0),
      .mem_wdata_o(mwd0), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
   );

   // stimulus tables
   logic        s_rst   [NC];
   logic        s_start [NC];
   logic [1:0]  s_op    [NC];
   logic [31:0] s_addr  [NC];
   logic [31:0] s_wdata [NC];
   logic [31:0] s_rdata [NC];
   logic        s_ack   [NC];
   // expectation tables
   logic        e_busy [NC];
   logic        e_done [NC];
   logic        e_err  [NC];
   logic        e_req  [NC];
   logic        e_we   [NC];
   logic        e_zero [NC];
   logic [31:0] e_addr [NC];
   logic [31:0] e_wd1  [NC];
   logic [31:0] e_wd0  [NC];

   int total = 0;
   int bad   = 0;
   int cur   = 0;
   logic run = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cur, act, exp);
      end
   endtask

   // Memory word as lanes; lane n is the byte at address offset n.
   function automatic logic [31:0] model_merge(input int le, input logic [1:0] o,
                                               input logic [31:0] a, input logic [31:0] wd,
                                               input logic [31:0] rd);
      logic [7:0]  b [4];
      logic [31:0] r;
      int          off;
      int          base;
      for (int i = 0; i < 4; i++) begin
         if (le != 0) b[i] = rd[8*i +: 8];
         else         b[i] = rd[8*(3-i) +: 8];
      end
      off  = int'(a[1:0]);
      base = off & 2;
      if (o == 2'b00) begin
         b[off] = wd[7:0];
      end else if (o == 2'b01) begin
         if (le != 0) begin
            b[base]   = wd[7:0];
            b[base+1] = wd[15:8];
         end else begin
            b[base]   = wd[15:8];
            b[base+1] = wd[7:0];
         end
      end else begin
         return wd;
      end
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (le != 0) r[8*i +: 8]     = b[i];
         else         r[8*(3-i) +: 8] = b[i];
      end
      return r;
   endfunction

   // Lay out one request starting (start high) in cycle k, with r ack-low
   // cycles in the read and w ack-low cycles in the write.
   task automatic plan(input int k, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int r, input int w);
      int  c;
      logic misal;
      s_start[k] = 1'b1;
      s_op[k]    = o;
      s_addr[k]  = a;
      s_wdata[k] = wd;
      misal = (o == 2'b11) || (o == 2'b01 && a[0]) || (o == 2'b10 && a[1:0] != 2'b00);
      if (misal) begin
         e_busy[k+1] = 1'b1;
         e_err[k+1]  = 1'b1;
      end else begin
         c = k + 1;
         if (o != 2'b10) begin
            for (int i = 0; i <= r; i++) begin
               e_busy[c+i] = 1'b1; e_req[c+i] = 1'b1; e_we[c+i] = 1'b0;
               e_addr[c+i] = {a[31:2], 2'b00};
               s_ack[c+i]  = (i == r);
               s_rdata[c+i] = rd;
            end
            c = c + r + 1;
         end
         for (int i = 0; i <= w; i++) begin
            e_busy[c+i] = 1'b1; e_req[c+i] = 1'b1; e_we[c+i] = 1'b1;
            e_addr[c+i] = {a[31:2], 2'b00};
            e_wd1[c+i]  = model_merge(1, o, a, wd, rd);
            e_wd0[c+i]  = model_merge(0, o, a, wd, rd);
            s_ack[c+i]  = (i == w);
         end
         c = c + w + 1;
         e_busy[c] = 1'b1;
         e_done[c] = 1'b1;
      end
   endtask

   // Reset high during cycle c: everything idle and cleared from c+1 on.
   task automatic do_reset(input int c);
      s_rst[c] = 1'b1;
      for (int j = c + 1; j <= c + 12 && j < NC; j++) begin
         e_busy[j] = 1'b0; e_done[j] = 1'b0; e_err[j] = 1'b0;
         e_req[j] = 1'b0;  e_we[j] = 1'b0;
      end
      e_zero[c+1] = 1'b1;
   endtask

   task automatic check_inst(input string tag, input logic b, input logic d,
                             input logic e, input logic rq, input logic we,
                             input logic [31:0] ma, input logic [31:0] wd,
                             input logic [31:0] ewd);
      chk({tag, "_busy"}, {31'h0, b}, {31'h0, e_busy[cur]});
      chk({tag, "_done"}, {31'h0, d}, {31'h0, e_done[cur]});
      chk({tag, "_err"},  {31'h0, e}, {31'h0, e_err[cur]});
      chk({tag, "_req"},  {31'h0, rq}, {31'h0, e_req[cur]});
      if (e_req[cur]) begin
         chk({tag, "_we"},   {31'h0, we}, {31'h0, e_we[cur]});
         chk({tag, "_addr"}, ma, e_addr[cur]);
         if (e_we[cur]) chk({tag, "_wdata"}, wd, ewd);
      end
      if (e_zero[cur]) begin
         chk({tag, "_rst_we"},    {31'h0, we}, 32'h0);
         chk({tag, "_rst_addr"},  ma, 32'h0);
         chk({tag, "_rst_wdata"}, wd, 32'h0);
      end
   endtask

   // Compare process: both instances against the tables, mid-cycle.
   always @(negedge clk) begin
      if (run) begin
         check_inst("le1", busy1, done1, err1, req1, we1, maddr1, mwd1, e_wd1[cur]);
         check_inst("le0", busy0, done0, err0, req0, we0, maddr0, mwd0, e_wd0[cur]);
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; addr = 32'h0;
      wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;

      for (int c = 0; c < NC; c++) begin
         s_rst[c] = 1'b0; s_start[c] = 1'b0; s_op[c] = 2'(c);
         s_addr[c] = 32'h5555_0000 | 32'(c); s_wdata[c] = 32'h1234_5678 ^ 32'(c);
         s_rdata[c] = 32'hCAFE_F00D; s_ack[c] = 1'b1;
         e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0; e_req[c] = 1'b0;
         e_we[c] = 1'b0; e_zero[c] = 1'b0; e_addr[c] = 32'h0;
         e_wd1[c] = 32'h0; e_wd0[c] = 32'h0;
      end

      // hand-computed pins on the merge model
      chk("pin_sb_le", model_merge(1, 2'b00, 32'h103, 32'hAABBCC5A, 32'h11223344), 32'h5A223344);
      chk("pin_sb_be", model_merge(0, 2'b00, 32'h103, 32'hAABBCC5A, 32'h11223344), 32'h1122335A);
      chk("pin_sh_le", model_merge(1, 2'b01, 32'h202, 32'h0000BEEF, 32'hFFFFFFFF), 32'hBEEFFFFF);
      chk("pin_sh_be", model_merge(0, 2'b01, 32'h202, 32'h0000BEEF, 32'hFFFFFFFF), 32'hFFFFBEEF);
      chk("pin_sw",    model_merge(1, 2'b10, 32'h010, 32'hDEADBEEF, 32'h00000000), 32'hDEADBEEF);

      for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
      for (int c = 0; c < 4; c++) e_zero[c] = 1'b1;

      plan(4,  2'b00, 32'h0000_0103, 32'hAABBCC5A, 32'h11223344, 0, 0);
      plan(9,  2'b01, 32'h0000_0202, 32'h0000BEEF, 32'hFFFFFFFF, 0, 0);
      plan(14, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 32'h00000000, 0, 0);
      plan(18, 2'b01, 32'h0000_0005, 32'h0000_1111, 32'h0, 0, 0);
      plan(21, 2'b10, 32'h0000_0006, 32'h2222_2222, 32'h0, 0, 0);
      plan(24, 2'b11, 32'h0000_0000, 32'h3333_3333, 32'h0, 0, 0);
      plan(27, 2'b00, 32'h0000_2001, 32'h0000_0077, 32'h89ABCDEF, 4, 3);
      // extra starts while busy must be ignored
      s_start[30] = 1'b1; s_op[30] = 2'b10; s_addr[30] = 32'h40; s_wdata[30] = 32'h9999_9999;
      s_start[34] = 1'b1; s_op[34] = 2'b00; s_addr[34] = 32'h41; s_wdata[34] = 32'h8888_8888;
      plan(40, 2'b01, 32'h0000_0300, 32'h1234ABCD, 32'h01020304, 1, 1);
      for (int i = 0; i < 4; i++)
         plan(47 + 5*i, 2'b00, 32'h0000_0500 + 32'(i), 32'h0000_009D, 32'hA1B2C3D4, 0, 0);
      plan(66, 2'b00, 32'h0000_0600, 32'h0000_0042, 32'h55667788, 0, 10);
      do_reset(70);
      plan(84, 2'b10, 32'h0000_0700, 32'hF00DCAFE, 32'h0, 0, 0);
      plan(88, 2'b10, 32'h0000_0704, 32'h0BADF00D, 32'h0, 0, 2);
      // reset wins over a simultaneous start
      s_start[95] = 1'b1; s_op[95] = 2'b10; s_addr[95] = 32'h80; s_wdata[95] = 32'h7777_7777;
      do_reset(95);

      for (int c = 0; c < NC; c++) begin
         @(posedge clk);
         #1;
         reset     = s_rst[c];
         start     = s_start[c];
         op        = s_op[c];
         addr      = s_addr[c];
         wdata     = s_wdata[c];
         mem_rdata = s_rdata[c];
         mem_ack   = s_ack[c];
         cur       = c;
         run       = 1'b1;
      end
      @(posedge clk);
      #1;
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
